// File: rtl/morse_capture.sv
// morse_capture: debounces a Morse key and assembles dot/dash symbols into characters of up to five symbols.
module morse_capture #(
  parameter int DEB_CYC  = 500000,
  parameter int DASH_CYC = 15000000,
  parameter int GAP_CYC  = 40000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [4:0] code,
  output logic [2:0] width,
  output logic       valid,
  output logic       err,
  output logic       busy
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int PW = $clog2(DASH_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0] DEB_FULL = DW'(DEB_CYC);
  localparam logic [PW-1:0] DASH_SAT = PW'(DASH_CYC);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [1:0] WAIT_UP = 2'd0, IDLE = 2'd1, DOWN = 2'd2, GAP = 2'd3;
  logic s1, s2, kd;
  logic [DW-1:0] dc, qc;
  logic [PW-1:0] pc;
  logic [GW-1:0] gc;
  logic [2:0] cnt;
  logic [4:0] sh;
  logic [1:0] state;
  assign busy = state[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {s1, s2, kd} <= '0;
      dc <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 == kd) dc <= '0;
      else if (dc == DEB_LAST) begin
        kd <= s2;
        dc <= '0;
      end else dc <= dc + 1'b1;
    end
  // WAIT_UP needs a full debounce window of released key, so a key held through reset never registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WAIT_UP;
      qc <= '0;
      pc <= '0;
      gc <= '0;
      cnt <= '0;
      sh <= '0;
      code <= '0;
      width <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      valid <= 1'b0;
      err <= 1'b0;
      case (state)
        WAIT_UP:
          if (kd || s2) qc <= '0;
          else if (qc == DEB_FULL) begin
            state <= IDLE;
            qc <= '0;
            pc <= '0;
            gc <= '0;
            cnt <= '0;
            sh <= '0;
          end else qc <= qc + 1'b1;
        IDLE:
          if (kd) begin
            state <= DOWN;
            pc <= '0;
          end
        DOWN:
          if (!kd) begin
            state <= GAP;
            gc <= '0;
            sh <= {sh[3:0], pc >= DASH_SAT};
            cnt <= (cnt == 3'd6) ? cnt : cnt + 3'd1;
          end else if (pc != DASH_SAT) pc <= pc + 1'b1;
        default:
          if (kd) begin
            state <= DOWN;
            gc <= '0;
            pc <= '0;
          end else if (gc == GAP_LAST) begin
            state <= IDLE;
            valid <= cnt != 3'd6;
            err <= cnt == 3'd6;
            if (cnt != 3'd6) begin
              code <= sh & ~(5'h1f << cnt);
              width <= cnt;
            end
            pc <= '0;
            gc <= '0;
            cnt <= '0;
            sh <= '0;
          end else gc <= gc + 1'b1;
      endcase
    end
endmodule
